beep_driver: RTL



---
 rtl/beep_pkg.sv | 16 +
 rtl/beep_tone_gen.sv | 40 ++++
 rtl/beep_driver.sv | 117 +++++++++++
 3 files changed

// File: rtl/beep_pkg.sv
// Shared types and default timing for the key-press buzzer driver.
package beep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Defaults for a 50 MHz sys_clk: 2 kHz tone, 100 ms bursts and gaps.
    localparam int TONE_HALF_DEF  = 12500;
    localparam int ON_CYCLES_DEF  = 5000000;
    localparam int GAP_CYCLES_DEF = 5000000;
    localparam int NUM_W_DEF      = 3;

endpackage

// File: rtl/beep_tone_gen.sv
// Square-wave tone generator: starts high on restart, toggles every TONE_HALF
// enabled clocks, and is held low with a cleared counter whenever disabled.
module beep_tone_gen
    import beep_pkg::*;
#(
    parameter int TONE_HALF = TONE_HALF_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic en,
    input  logic restart,
    output logic tone
);

    localparam int TW = $clog2(TONE_HALF + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(TONE_HALF - 1);

    logic [TW-1:0] tone_cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tone_cnt <= '0;
            tone     <= 1'b0;
        end else if (restart) begin
            tone_cnt <= '0;
            tone     <= 1'b1;
        end else if (en) begin
            if (tone_cnt == HALF_LAST) begin
                tone_cnt <= '0;
                tone     <= ~tone;
            end else begin
                tone_cnt <= tone_cnt + TW'(1);
            end
        end else begin
            tone_cnt <= '0;
            tone     <= 1'b0;
        end
    end

endmodule

// File: rtl/beep_driver.sv
// Buzzer driver: each falling edge of the debounced key plays beep_num tone
// bursts separated by silent gaps, reporting busy and a done pulse.
//
//   state | meaning
//   IDLE  | silent, waiting for a key press
//   ON    | tone burst, ON_CYCLES clocks
//   GAP   | silence between bursts, GAP_CYCLES clocks
module beep_driver
    import beep_pkg::*;
#(
    parameter int TONE_HALF  = TONE_HALF_DEF,
    parameter int ON_CYCLES  = ON_CYCLES_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF,
    parameter int NUM_W      = NUM_W_DEF
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             key_filter,
    input  logic [NUM_W-1:0] beep_num,
    output logic             beep,
    output logic             busy,
    output logic             done
);

    localparam int DUR_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int DUR_W   = $clog2(DUR_MAX + 1);
    localparam logic [DUR_W-1:0] ON_LAST  = DUR_W'(ON_CYCLES - 1);
    localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(GAP_CYCLES - 1);

    state_t             state;
    state_t             state_next;
    logic [DUR_W-1:0]   dur_cnt;
    logic [DUR_W-1:0]   dur_next;
    logic [NUM_W-1:0]   rem;
    logic [NUM_W-1:0]   rem_next;
    logic               key_d;
    logic               press;
    logic               busy_next;
    logic               done_next;
    logic               tone_en;
    logic               tone_restart;

    assign press = key_d & ~key_filter;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state   <= IDLE;
            dur_cnt <= '0;
            rem     <= '0;
            key_d   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            dur_cnt <= dur_next;
            rem     <= rem_next;
            key_d   <= key_filter;
            busy    <= busy_next;
            done    <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        dur_next   = dur_cnt + DUR_W'(1);
        rem_next   = rem;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                dur_next = '0;
                if (press) begin
                    rem_next   = (beep_num == '0) ? NUM_W'(1) : beep_num;
                    state_next = ON;
                end
            end
            ON: begin
                if (dur_cnt == ON_LAST) begin
                    dur_next = '0;
                    if (rem > NUM_W'(1)) begin
                        rem_next   = rem - NUM_W'(1);
                        state_next = GAP;
                    end else begin
                        rem_next   = '0;
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            GAP: begin
                if (dur_cnt == GAP_LAST) begin
                    dur_next   = '0;
                    state_next = ON;
                end
            end
            default: begin
                dur_next   = '0;
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    // Tone phase restarts high at every ON entry and is forced low outside ON.
    assign tone_restart = (state_next == ON) && (state != ON);
    assign tone_en      = (state_next == ON) && (state == ON);

    beep_tone_gen #(
        .TONE_HALF (TONE_HALF)
    ) u_tone (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .en      (tone_en),
        .restart (tone_restart),
        .tone    (beep)
    );

endmodule
